// File: rtl/execute_stage.sv
// EX stage: operand forwarding from MEM/WB, 64-bit ALU, branch target, EX/MEM register.
// Latency 1 cycle (all outputs registered); no backpressure, captures every rising edge.
// Backpressure: none; stalls and flushes are handled upstream by zeroing the control bits.
module execute_stage (
    input  logic        clk,
    input  logic        resetl,
    input  logic        RegWrite_EX,
    input  logic        ALUSrc_EX,
    input  logic        Branch_EX,
    input  logic        Uncondbranch_EX,
    input  logic        MemRead_EX,
    input  logic        MemWrite_EX,
    input  logic        Mem2Reg_EX,
    input  logic [3:0]  ALUOp_EX,
    input  logic [4:0]  RD_EX,
    input  logic [4:0]  rm_EX,
    input  logic [4:0]  rn_EX,
    input  logic [63:0] RegOutA_EX,
    input  logic [63:0] RegOutB_EX,
    input  logic [63:0] SignExtImm64_EX,
    input  logic [63:0] pc_EX,
    input  logic [63:0] aluout_MEM,
    input  logic [63:0] memtoregout_WB,
    input  logic        regwrite_WB,
    input  logic [4:0]  rd_WB,
    output logic        RegWrite_MEM,
    output logic        Branch_MEM,
    output logic        Uncondbranch_MEM,
    output logic        MemRead_MEM,
    output logic        MemWrite_MEM,
    output logic        Mem2Reg_MEM,
    output logic        ALUzero_MEM,
    output logic [4:0]  RD_MEM,
    output logic [63:0] RegOutB_MEM,
    output logic [63:0] ALUout_MEM,
    output logic [63:0] PCtarget_MEM,
    output logic [63:0] pc_MEM
);

    localparam logic [4:0] XZR      = 5'd31;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_ORR  = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_PASS = 4'b0111;

    typedef struct packed {
        logic        regwrite;
        logic        branch;
        logic        uncondbranch;
        logic        memread;
        logic        memwrite;
        logic        mem2reg;
        logic        aluzero;
        logic [4:0]  rd;
        logic [63:0] regoutb;
        logic [63:0] aluout;
        logic [63:0] pctarget;
        logic [63:0] pc;
    } exmem_t;

    exmem_t      ex_mem_q;
    exmem_t      ex_mem_d;
    logic [63:0] fwd_a;
    logic [63:0] fwd_b;
    logic [63:0] alu_b;
    logic [63:0] alu_res;

    // MEM (our own registered result) outranks WB; XZR reads as the register file gives it.
    always_comb begin
        fwd_a = RegOutA_EX;
        if (ex_mem_q.regwrite && (ex_mem_q.rd == rn_EX) && (rn_EX != XZR)) begin
            fwd_a = aluout_MEM;
        end else if (regwrite_WB && (rd_WB == rn_EX) && (rn_EX != XZR)) begin
            fwd_a = memtoregout_WB;
        end

        fwd_b = RegOutB_EX;
        if (ex_mem_q.regwrite && (ex_mem_q.rd == rm_EX) && (rm_EX != XZR)) begin
            fwd_b = aluout_MEM;
        end else if (regwrite_WB && (rd_WB == rm_EX) && (rm_EX != XZR)) begin
            fwd_b = memtoregout_WB;
        end
    end

    assign alu_b = ALUSrc_EX ? SignExtImm64_EX : fwd_b;

    always_comb begin
        alu_res = '0;
        case (ALUOp_EX)
            ALU_AND:  alu_res = fwd_a & alu_b;
            ALU_ORR:  alu_res = fwd_a | alu_b;
            ALU_ADD:  alu_res = fwd_a + alu_b;
            ALU_SUB:  alu_res = fwd_a - alu_b;
            ALU_PASS: alu_res = alu_b;
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        ex_mem_d              = '0;
        ex_mem_d.regwrite     = RegWrite_EX;
        ex_mem_d.branch       = Branch_EX;
        ex_mem_d.uncondbranch = Uncondbranch_EX;
        ex_mem_d.memread      = MemRead_EX;
        ex_mem_d.memwrite     = MemWrite_EX;
        ex_mem_d.mem2reg      = Mem2Reg_EX;
        ex_mem_d.aluzero      = (alu_res == 64'd0);
        ex_mem_d.rd           = RD_EX;
        // Store data is the forwarded register value, never the immediate.
        ex_mem_d.regoutb      = fwd_b;
        ex_mem_d.aluout       = alu_res;
        ex_mem_d.pctarget     = pc_EX + SignExtImm64_EX;
        ex_mem_d.pc           = pc_EX;
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            ex_mem_q <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
        end
    end

    assign RegWrite_MEM     = ex_mem_q.regwrite;
    assign Branch_MEM       = ex_mem_q.branch;
    assign Uncondbranch_MEM = ex_mem_q.uncondbranch;
    assign MemRead_MEM      = ex_mem_q.memread;
    assign MemWrite_MEM     = ex_mem_q.memwrite;
    assign Mem2Reg_MEM      = ex_mem_q.mem2reg;
    assign ALUzero_MEM      = ex_mem_q.aluzero;
    assign RD_MEM           = ex_mem_q.rd;
    assign RegOutB_MEM      = ex_mem_q.regoutb;
    assign ALUout_MEM       = ex_mem_q.aluout;
    assign PCtarget_MEM     = ex_mem_q.pctarget;
    assign pc_MEM           = ex_mem_q.pc;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboarded random + directed bench for execute_stage against a behavioural model.
module tb_execute_stage;

    typedef struct packed {
        logic        rw, alusrc, br, ub, mr, mw, m2r;
        logic [3:0]  op;
        logic [4:0]  rd, rm, rn;
        logic [63:0] a, b, imm, pc, amem, wbdat;
        logic        wbrw;
        logic [4:0]  wbrd;
    } stim_t;

    typedef struct packed {
        logic        rw, br, ub, mr, mw, m2r, zero;
        logic [4:0]  rd;
        logic [63:0] regb, aluout, pct, pc;
    } resp_t;

    logic        clk = 1'b0;
    logic        resetl = 1'b0;
    logic        RegWrite_EX, ALUSrc_EX, Branch_EX, Uncondbranch_EX;
    logic        MemRead_EX, MemWrite_EX, Mem2Reg_EX;
    logic [3:0]  ALUOp_EX;
    logic [4:0]  RD_EX, rm_EX, rn_EX;
    logic [63:0] RegOutA_EX, RegOutB_EX, SignExtImm64_EX, pc_EX;
    logic [63:0] aluout_MEM, memtoregout_WB;
    logic        regwrite_WB;
    logic [4:0]  rd_WB;
    logic        RegWrite_MEM, Branch_MEM, Uncondbranch_MEM, MemRead_MEM;
    logic        MemWrite_MEM, Mem2Reg_MEM, ALUzero_MEM;
    logic [4:0]  RD_MEM;
    logic [63:0] RegOutB_MEM, ALUout_MEM, PCtarget_MEM, pc_MEM;

    execute_stage dut (
        .clk(clk), .resetl(resetl),
        .RegWrite_EX(RegWrite_EX), .ALUSrc_EX(ALUSrc_EX), .Branch_EX(Branch_EX),
        .Uncondbranch_EX(Uncondbranch_EX), .MemRead_EX(MemRead_EX),
        .MemWrite_EX(MemWrite_EX), .Mem2Reg_EX(Mem2Reg_EX), .ALUOp_EX(ALUOp_EX),
        .RD_EX(RD_EX), .rm_EX(rm_EX), .rn_EX(rn_EX),
        .RegOutA_EX(RegOutA_EX), .RegOutB_EX(RegOutB_EX),
        .SignExtImm64_EX(SignExtImm64_EX), .pc_EX(pc_EX),
        .aluout_MEM(aluout_MEM), .memtoregout_WB(memtoregout_WB),
        .regwrite_WB(regwrite_WB), .rd_WB(rd_WB),
        .RegWrite_MEM(RegWrite_MEM), .Branch_MEM(Branch_MEM),
        .Uncondbranch_MEM(Uncondbranch_MEM), .MemRead_MEM(MemRead_MEM),
        .MemWrite_MEM(MemWrite_MEM), .Mem2Reg_MEM(Mem2Reg_MEM),
        .ALUzero_MEM(ALUzero_MEM), .RD_MEM(RD_MEM), .RegOutB_MEM(RegOutB_MEM),
        .ALUout_MEM(ALUout_MEM), .PCtarget_MEM(PCtarget_MEM), .pc_MEM(pc_MEM)
    );

    always #5 clk = ~clk;

    int    n_vec = 0;
    int    n_bad = 0;
    resp_t exp_q[$];
    string tag_q[$];
    // Model of what the DUT's MEM-stage register currently holds.
    logic       m_rw = 1'b0;
    logic [4:0] m_rd = 5'd0;

    function automatic resp_t dut_out();
        return {RegWrite_MEM, Branch_MEM, Uncondbranch_MEM, MemRead_MEM, MemWrite_MEM,
                Mem2Reg_MEM, ALUzero_MEM, RD_MEM, RegOutB_MEM, ALUout_MEM,
                PCtarget_MEM, pc_MEM};
    endfunction

    function automatic logic [63:0] operand(input logic [4:0] idx, input logic [63:0] rf,
                                            input stim_t s);
        if (idx == 5'd31) return rf;
        if (m_rw && m_rd == idx) return s.amem;
        if (s.wbrw && s.wbrd == idx) return s.wbdat;
        return rf;
    endfunction

    function automatic resp_t model(input stim_t s);
        resp_t r;
        logic [63:0] x, y, bop;
        x   = operand(s.rn, s.a, s);
        y   = operand(s.rm, s.b, s);
        bop = s.alusrc ? s.imm : y;
        case (s.op)
            4'd0:    r.aluout = x & bop;
            4'd1:    r.aluout = x | bop;
            4'd2:    r.aluout = x + bop;
            4'd6:    r.aluout = x - bop;
            4'd7:    r.aluout = bop;
            default: r.aluout = 64'd0;
        endcase
        r.zero = (r.aluout == 64'd0);
        r.rw = s.rw; r.br = s.br; r.ub = s.ub; r.mr = s.mr; r.mw = s.mw; r.m2r = s.m2r;
        r.rd = s.rd; r.regb = y; r.pct = s.pc + s.imm; r.pc = s.pc;
        return r;
    endfunction

    task automatic drive(input stim_t s);
        RegWrite_EX = s.rw; ALUSrc_EX = s.alusrc; Branch_EX = s.br; Uncondbranch_EX = s.ub;
        MemRead_EX = s.mr; MemWrite_EX = s.mw; Mem2Reg_EX = s.m2r; ALUOp_EX = s.op;
        RD_EX = s.rd; rm_EX = s.rm; rn_EX = s.rn; RegOutA_EX = s.a; RegOutB_EX = s.b;
        SignExtImm64_EX = s.imm; pc_EX = s.pc; aluout_MEM = s.amem;
        memtoregout_WB = s.wbdat; regwrite_WB = s.wbrw; rd_WB = s.wbrd;
    endtask

    task automatic apply(input stim_t s, input string tag);
        @(negedge clk);
        drive(s);
        exp_q.push_back(model(s));
        tag_q.push_back(tag);
        m_rw = s.rw;
        m_rd = s.rd;
    endtask

    task automatic check_zero(input string tag);
        resp_t got;
        got = dut_out();
        n_vec++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL %s: got %h expected all zero", tag, got);
        end
    endtask

    function automatic stim_t quiet();
        stim_t s;
        s = '0;
        s.rn = 5'd1; s.rm = 5'd2;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        logic [4:0] pick [4];
        s = '0;
        {s.rw, s.alusrc, s.br, s.ub, s.mr, s.mw, s.m2r, s.wbrw} = 8'($urandom);
        case ($urandom_range(0, 5))
            0: s.op = 4'd0; 1: s.op = 4'd1; 2: s.op = 4'd2;
            3: s.op = 4'd6; 4: s.op = 4'd7; default: s.op = 4'($urandom);
        endcase
        s.rd   = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
        s.wbrd = 5'($urandom_range(0, 7));
        pick[0] = m_rd; pick[1] = s.wbrd; pick[2] = 5'd31; pick[3] = 5'($urandom);
        s.rn = pick[$urandom_range(0, 3)];
        s.rm = pick[$urandom_range(0, 3)];
        s.a     = {$urandom, $urandom};
        s.b     = ($urandom_range(0, 3) == 0) ? s.a : {$urandom, $urandom};
        s.imm   = {$urandom, $urandom};
        s.pc    = {$urandom, $urandom};
        s.amem  = {$urandom, $urandom};
        s.wbdat = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) begin
            s.amem = s.imm; s.wbdat = s.b;
        end
        return s;
    endfunction

    initial begin : monitor
        resp_t got, exp;
        string tag;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                tag = tag_q.pop_front();
                got = dut_out();
                n_vec++;
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h", tag, got, exp);
                end
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        drive(rand_stim());
        repeat (3) begin
            @(posedge clk);
            #1;
            check_zero("reset_hold");
        end
        #2 resetl = 1'b1;

        s = quiet(); s.alusrc = 1; s.mw = 1; s.op = 4'd2; s.rd = 5'd14;
        s.a = 64'd6; s.b = 64'd0; s.imm = 64'd4; s.pc = 64'd0;
        apply(s, "stur");
        s = quiet(); s.ub = 1; s.pc = 64'd4; s.imm = 64'd8;
        apply(s, "b");
        s = quiet(); s.br = 1; s.op = 4'b1111; s.rd = 5'd12; s.pc = 64'hC;
        s.imm = -64'sd12;
        apply(s, "cbz");

        s = quiet(); s.rw = 1; s.rd = 5'd5; s.op = 4'd2;
        apply(s, "fwd_setup");
        s = quiet(); s.rw = 1; s.rd = 5'd5; s.rn = 5'd5; s.amem = 64'h20; s.op = 4'd2;
        s.imm = 64'd1; s.alusrc = 1; s.a = 64'h777;
        apply(s, "fwd_mem_a");
        s.wbrw = 1; s.wbrd = 5'd5; s.wbdat = 64'h99; s.rw = 0;
        apply(s, "fwd_mem_over_wb");
        s = quiet(); s.rm = 5'd5; s.b = 64'h1234; s.wbrw = 1; s.wbrd = 5'd5;
        s.wbdat = 64'h99; s.op = 4'd7;
        apply(s, "fwd_wb_b");
        s = quiet(); s.rw = 1; s.rd = 5'd31; s.op = 4'd2;
        apply(s, "x31_setup");
        s = quiet(); s.rn = 5'd31; s.rm = 5'd31; s.a = 64'h11; s.b = 64'h22;
        s.amem = 64'hAA; s.wbrw = 1; s.wbrd = 5'd31; s.wbdat = 64'hBB; s.op = 4'd2;
        apply(s, "x31_no_fwd");

        foreach (s.op[i]) begin end
        for (int k = 0; k < 6; k++) begin
            logic [3:0] ops [6];
            ops[0] = 4'd0; ops[1] = 4'd1; ops[2] = 4'd2;
            ops[3] = 4'd6; ops[4] = 4'd7; ops[5] = 4'd6;
            s = quiet(); s.op = ops[k];
            s.a = (k == 5) ? 64'd0 : 64'hF0;
            s.b = (k == 5) ? 64'd1 : 64'h3C;
            apply(s, $sformatf("alu_op%0d", k));
        end

        for (int k = 0; k < 400; k++) begin
            apply(rand_stim(), $sformatf("rand%0d", k));
        end

        @(posedge clk);
        #2;
        resetl = 1'b0;
        #1;
        check_zero("async_reset");
        #1 resetl = 1'b1;
        m_rw = 1'b0;
        m_rd = 5'd0;
        for (int k = 0; k < 50; k++) begin
            apply(rand_stim(), $sformatf("post_rst%0d", k));
        end

        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
